// File: rtl/ysyx_22050518_div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : FSM state encoding (IDLE, PREP, CALC, FIX, DONE)
//   DIV0_Q      : divide-by-zero quotient (all ones). It is sliced to XLEN by users,
//                 so XLEN may not exceed DIV_MAX_XLEN.
package ysyx_22050518_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam int DIV_MAX_XLEN = 128;
  localparam logic [DIV_MAX_XLEN-1:0] DIV0_Q = '1;

endpackage

// File: rtl/ysyx_22050518_div_step.sv
// One restoring-division step (combinational).
//   rem     in  XLEN  partial remainder (always < divisor)
//   dvd_msb in  1     next dividend bit shifted into the remainder
//   divisor in  XLEN  divisor magnitude
//   rem_nxt out XLEN  remainder after the trial subtraction
//   q_bit   out 1     quotient bit produced by this step
module ysyx_22050518_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  always_comb begin
    shifted = {rem, dvd_msb};
    q_bit   = (shifted >= {1'b0, divisor});
    // rem < divisor, so shifted < 2*divisor and the true difference fits in
    // XLEN bits; a modulo-2^XLEN subtraction gives the exact result.
    rem_nxt = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22050518_iter_div.sv
// Radix-2 restoring iterative divider for RISC-V DIV/DIVU/REM/REMU and W forms.
// Ports:
//   clk, rst_n (synchronous, active-low), flush (kills the in-flight op)
//   in_valid/in_ready, dividend, divisor, is_word, is_signed, in_tag : request
//   out_valid/out_ready, quotient, remainder, out_tag                  : result
// Optional: define YSYX_22050518_DIV_EARLY_OUT_EN to skip the leading zero
// bits of |dividend| (variable latency, identical results).
module ysyx_22050518_iter_div
  import ysyx_22050518_div_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic             is_word,
  input  logic             is_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  quotient,
  output logic [XLEN-1:0]  remainder,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_D = {XLEN{1'b1}} << (XLEN - 1);
  localparam logic [XLEN-1:0] MIN_W = {XLEN{1'b1}} << (H - 1);

  div_state_e state, state_nxt;
  logic       accept;

  // request latched at the accepting edge
  logic [XLEN-1:0]  a_r, b_r;
  logic             word_r, sgn_r;
  logic [TAG_W-1:0] tag_r;

  // iteration state; dvd doubles as the quotient shift register
  logic [XLEN-1:0] dvd, rem, div_abs;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg, spec;

  logic [XLEN-1:0] a_eff, b_eff, a_abs, b_abs, spec_q, spec_r, dvd_init;
  logic            a_neg, b_neg, div0, ovf, special, skip_calc;
  logic [CW-1:0]   n_eff, cnt_init;
  logic [XLEN-1:0] step_rem, q_s, r_s, fix_q, fix_r;
  logic            step_q;

  function automatic logic [XLEN-1:0] sext_h(input logic [H-1:0] v);
    return {{H{v[H-1]}}, v};
  endfunction

  // ---------------- operand preparation (used in PREP) ----------------
  always_comb begin
    n_eff   = word_r ? CW'(H) : CW'(XLEN);
    a_eff   = word_r ? {{H{sgn_r & a_r[H-1]}}, a_r[H-1:0]} : a_r;
    b_eff   = word_r ? {{H{sgn_r & b_r[H-1]}}, b_r[H-1:0]} : b_r;
    a_neg   = sgn_r & a_eff[XLEN-1];
    b_neg   = sgn_r & b_eff[XLEN-1];
    a_abs   = a_neg ? -a_eff : a_eff;
    b_abs   = b_neg ? -b_eff : b_eff;
    div0    = (b_eff == '0);
    ovf     = sgn_r & (a_eff == (word_r ? MIN_W : MIN_D)) & (b_eff == '1);
    special = div0 | ovf;
    spec_q  = div0 ? DIV0_Q[XLEN-1:0] : a_eff;
    // W results are always sign-extended from bit H-1, REMUW x/0 included
    spec_r  = div0 ? (word_r ? sext_h(a_r[H-1:0]) : a_eff) : '0;
  end

`ifdef YSYX_22050518_DIV_EARLY_OUT_EN
  logic [XLEN-1:0] a_al;
  logic [CW-1:0]   lz;

  // Leading zeros of |dividend| within N bits; N when the dividend is zero.
  // The W operand is first aligned to the top so one counter serves both widths.
  always_comb begin
    a_al = word_r ? (a_abs << H) : a_abs;
    lz   = n_eff;
    for (int i = 0; i < XLEN; i++)
      if (a_al[i]) lz = CW'(XLEN - 1 - i);
    dvd_init  = a_al << lz;
    cnt_init  = n_eff - CW'(1) - lz;
    skip_calc = (lz == n_eff);
  end
`else
  always_comb begin
    dvd_init  = word_r ? (a_abs << H) : a_abs;
    cnt_init  = n_eff - CW'(1);
    skip_calc = 1'b0;
  end
`endif

  ysyx_22050518_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[XLEN-1]),
    .divisor (div_abs),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  // ---------------- sign fix-up (used in FIX) ----------------
  always_comb begin
    q_s   = q_neg ? -dvd : dvd;
    r_s   = r_neg ? -rem : rem;
    // special-case results were finalised in PREP and pass through untouched
    fix_q = spec ? dvd : (word_r ? sext_h(q_s[H-1:0]) : q_s);
    fix_r = spec ? rem : (word_r ? sext_h(r_s[H-1:0]) : r_s);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      // special cases also route through FIX so they share the 2-edge latency
      PREP:    state_nxt = (special | skip_calc) ? FIX : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? PREP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = ((state == IDLE) | ((state == DONE) & out_ready)) & ~flush;
    out_valid = (state == DONE);
    accept    = in_valid & in_ready;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      word_r    <= 1'b0;
      sgn_r     <= 1'b0;
      tag_r     <= '0;
      dvd       <= '0;
      rem       <= '0;
      div_abs   <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      spec      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_tag   <= '0;
    end else begin
      if (accept) begin
        a_r    <= dividend;
        b_r    <= divisor;
        word_r <= is_word;
        sgn_r  <= is_signed;
        tag_r  <= in_tag;
      end
      case (state)
        PREP: begin
          spec    <= special;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          div_abs <= b_abs;
          cnt     <= cnt_init;
          dvd     <= special ? spec_q : dvd_init;
          rem     <= special ? spec_r : '0;
        end
        CALC: begin
          dvd <= {dvd[XLEN-2:0], step_q};
          rem <= step_rem;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // visible outputs change only when DONE is actually entered
          if (!flush) begin
            quotient  <= fix_q;
            remainder <= fix_r;
            out_tag   <= tag_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
